// File: rtl/osd_pkg.sv
// rtl/osd_pkg.sv - OSD SPI command opcodes, cmd_op encoding and FSM state codes
package osd_pkg;

  localparam logic [7:0] OSD_CMD_DISABLE = 8'h40;
  localparam logic [7:0] OSD_CMD_ENABLE  = 8'h41;
  localparam logic [3:0] OSD_CMD_WRITE   = 4'h2;
  localparam int         OSD_LINE_BYTES  = 256;

  localparam logic [1:0] OP_DISABLE = 2'd0;
  localparam logic [1:0] OP_ENABLE  = 2'd1;
  localparam logic [1:0] OP_WRITE   = 2'd2;
  localparam logic [1:0] OP_NOP     = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_FETCH = 3'd4;
  localparam logic [2:0] ST_TAIL  = 3'd5;
  localparam logic [2:0] ST_GAP   = 3'd6;

  // Small OSDs only address 8 lines, so line[3] is dropped unless big is set.
  function automatic logic [7:0] osd_cmd_byte(input logic [1:0] op, input logic [3:0] line,
                                              input logic big);
    case (op)
      OP_DISABLE: return OSD_CMD_DISABLE;
      OP_ENABLE:  return OSD_CMD_ENABLE;
      OP_WRITE:   return {OSD_CMD_WRITE, big & line[3], line[2:0]};
      default:    return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/osd_spi_shift.sv
// rtl/osd_spi_shift.sv - MSB-first byte shifter with CLK_DIV half-period SCK timer (mode 0)
module osd_spi_shift #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       start,
  output logic       sck,
  output logic       di,
  output logic       tick,
  output logic       byte_done
);

  logic [7:0] sr;
  logic [7:0] tmr;
  logic [2:0] bits;
  logic       run;

  // tick marks the last clk_sys cycle of a half period; the SCK edge lands on the next clock.
  assign tick      = run && (tmr == 8'(CLK_DIV - 1));
  assign byte_done = tick && sck && (bits == 3'd7);
  assign di        = sr[7];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sr   <= 8'h00;
      tmr  <= 8'h00;
      bits <= 3'd0;
      run  <= 1'b0;
      sck  <= 1'b0;
    end else if (load) begin
      sr   <= tx_byte;
      bits <= 3'd0;
      tmr  <= 8'h00;
      sck  <= 1'b0;
      run  <= start;
    end else if (start) begin
      tmr <= 8'h00;
      run <= 1'b1;
    end else if (tick) begin
      tmr <= 8'h00;
      sck <= ~sck;
      // The next bit is presented in the same cycle SCK falls.
      if (sck) begin
        if (bits == 3'd7) begin
          run <= 1'b0;
        end else begin
          sr   <= {sr[6:0], 1'b0};
          bits <= bits + 3'd1;
        end
      end
    end else if (run) begin
      tmr <= tmr + 8'd1;
    end
  end

endmodule

// File: rtl/osd_spi_master.sv
// rtl/osd_spi_master.sv - SPI initiator issuing OSD enable/disable/write-line commands
module osd_spi_master
  import osd_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned LINE_BYTES = OSD_LINE_BYTES,
  parameter int unsigned SS_GAP     = 4,
  parameter bit          BIG_OSD    = 1'b0
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_line,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       SPI_SCK,
  output logic       SPI_SS3,
  output logic       SPI_DI
);

  logic [2:0] state;
  logic [1:0] op;
  logic [8:0] cnt;
  logic [7:0] tmr;
  logic       armed;
  logic       ss_n;
  logic       done_q;
  logic       accept;
  logic       take;
  logic       sh_load;
  logic       sh_start;
  logic [7:0] sh_byte;
  logic       tick;
  logic       byte_done;

  assign accept     = cmd_valid && cmd_ready;
  assign take       = (state == ST_FETCH) && data_valid;
  assign cmd_ready  = armed && (state == ST_IDLE);
  assign data_ready = (state == ST_FETCH);
  assign busy       = (state != ST_IDLE);
  assign done       = done_q;
  assign SPI_SS3    = ss_n;

  assign sh_load  = (accept && (cmd_op != OP_NOP)) || take;
  assign sh_start = (state == ST_LOAD) || take;
  assign sh_byte  = take ? data : osd_cmd_byte(cmd_op, cmd_line, BIG_OSD);

  osd_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .load      (sh_load),
    .tx_byte   (sh_byte),
    .start     (sh_start),
    .sck       (SPI_SCK),
    .di        (SPI_DI),
    .tick      (tick),
    .byte_done (byte_done)
  );

  // ss_n is a flop with async set so a reset drops the frame immediately.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      op     <= OP_DISABLE;
      cnt    <= 9'd0;
      tmr    <= 8'h00;
      armed  <= 1'b0;
      ss_n   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      armed  <= 1'b1;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op  <= cmd_op;
            cnt <= 9'd0;
            tmr <= 8'h00;
            if (cmd_op == OP_NOP) begin
              state  <= ST_GAP;
              done_q <= 1'b1;
            end else begin
              state <= ST_LOAD;
              ss_n  <= 1'b0;
            end
          end
        end
        ST_LOAD: state <= ST_LOW;
        ST_LOW:  if (tick) state <= ST_HIGH;
        ST_HIGH: begin
          if (byte_done)
            state <= ((op == OP_WRITE) && (cnt < 9'(LINE_BYTES))) ? ST_FETCH : ST_TAIL;
          else if (tick)
            state <= ST_LOW;
        end
        // An empty source stalls here with SCK low; the edge-triggered slave keeps its place.
        ST_FETCH: begin
          if (data_valid) begin
            cnt   <= cnt + 9'd1;
            state <= ST_LOW;
          end
        end
        ST_TAIL: begin
          if (tmr == 8'(CLK_DIV - 1)) begin
            tmr    <= 8'h00;
            ss_n   <= 1'b1;
            done_q <= 1'b1;
            state  <= ST_GAP;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        ST_GAP: begin
          if (tmr == 8'(SS_GAP - 1)) begin
            tmr   <= 8'h00;
            state <= ST_IDLE;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_spi_master.sv
// tb/tb_osd_spi_master.sv - self-checking bench: command table, SPI slave model, byte scoreboard
module tb_osd_spi_master;

  localparam int CLK_DIV    = 2;
  localparam int LINE_BYTES = 256;
  localparam int SS_GAP     = 4;

  typedef struct {
    logic [1:0] op;
    logic [3:0] line;
    logic [7:0] exp_cmd;
    logic [7:0] exp_big;
    int         exp_frame;
  } vec_t;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_line = 4'd0;
  logic       data_valid;
  logic [7:0] data;
  logic       cmd_ready, data_ready, busy, done, SPI_SCK, SPI_SS3, SPI_DI;
  logic       big_cmd_ready, big_data_ready, big_busy, big_done, big_sck, big_ss3, big_di;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] big_q[$];
  logic [7:0] buffer[0:4095];

  int hs_cnt = 0, src_base = 0, stall_at = -1, stall_left = 0;
  logic src_en = 1'b0;

  int  fr_bytes = 0, fr_rises = 0, bitc = 0, hi_run = 0, hi_min = 0, hi_max = 0;
  int  last_bytes = 0, last_rises = 0, last_hi_min = 0, last_hi_max = 0;
  int  idle_rises = 0, done_cnt = 0, ss_run = 0, gap_min = 999;
  int  stall_fetch = 0, stall_bad = 0;
  logic gap_arm = 1'b0;
  logic ss_prev = 1'b1, sck_prev = 1'b0;
  logic [7:0] shreg = 8'h00, fr_cmd = 8'h00;
  int  bbit = 0;
  logic bfirst = 1'b0, bss_prev = 1'b1, bsck_prev = 1'b0;
  logic [7:0] bsh = 8'h00;

  always #5 clk_sys = ~clk_sys;

  osd_spi_master #(.CLK_DIV(CLK_DIV), .LINE_BYTES(LINE_BYTES), .SS_GAP(SS_GAP), .BIG_OSD(1'b0)) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_line(cmd_line), .data_valid(data_valid), .data_ready(data_ready),
    .data(data), .busy(busy), .done(done), .SPI_SCK(SPI_SCK), .SPI_SS3(SPI_SS3), .SPI_DI(SPI_DI));

  osd_spi_master #(.CLK_DIV(CLK_DIV), .LINE_BYTES(LINE_BYTES), .SS_GAP(SS_GAP), .BIG_OSD(1'b1)) u_big (
    .clk_sys(clk_sys), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(big_cmd_ready),
    .cmd_op(cmd_op), .cmd_line(cmd_line), .data_valid(data_valid), .data_ready(big_data_ready),
    .data(data), .busy(big_busy), .done(big_done), .SPI_SCK(big_sck), .SPI_SS3(big_ss3), .SPI_DI(big_di));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Payload source: byte value is its index within the current command; expected byte queued on handshake.
  initial begin
    logic hs;
    data_valid = 1'b0;
    data = 8'h00;
    forever begin
      @(negedge clk_sys);
      hs = data_ready && data_valid;
      @(posedge clk_sys);
      #1;
      if (hs) begin
        exp_q.push_back(data);
        hs_cnt++;
        if (hs_cnt - src_base == stall_at) stall_left = 50;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      data = 8'(hs_cnt - src_base);
      data_valid = src_en && (stall_left == 0);
    end
  end

  // Slave model for the BIG_OSD=0 instance: deserialises on SCK rise, scores every byte, fills line buffer.
  always @(negedge clk_sys) begin
    if (!SPI_SS3) begin
      if (ss_prev) begin
        fr_bytes = 0; fr_rises = 0; bitc = 0; hi_min = 999; hi_max = 0;
      end
      if (SPI_SCK && !sck_prev) begin
        shreg = {shreg[6:0], SPI_DI};
        bitc++;
        fr_rises++;
        if (bitc == 8) begin
          bitc = 0;
          if (exp_q.size() == 0) begin
            chk("spi_byte_unexpected", int'(shreg), -1);
          end else begin
            chk("spi_byte", int'(shreg), int'(exp_q.pop_front()));
          end
          if (fr_bytes == 0) fr_cmd = shreg;
          else if (fr_cmd[7:4] == 4'h2) buffer[{fr_cmd[3:0], 8'(fr_bytes - 1)}] = shreg;
          fr_bytes++;
        end
      end
    end else if (SPI_SCK && !sck_prev) begin
      idle_rises++;
    end
    if (SPI_SCK) hi_run++;
    else if (sck_prev) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      hi_run = 0;
    end
    if (SPI_SS3 && !ss_prev) begin
      last_bytes = fr_bytes; last_rises = fr_rises; last_hi_min = hi_min; last_hi_max = hi_max;
    end
    if (SPI_SS3) ss_run++;
    else if (ss_prev) begin
      if (gap_arm && ss_run < gap_min) gap_min = ss_run;
      ss_run = 0;
    end
    if (!gap_arm) gap_min = 999;
    if (done) done_cnt++;
    if (stall_left > 0 && data_ready) begin
      stall_fetch++;
      if (SPI_SCK || SPI_SS3) stall_bad++;
    end
    ss_prev = SPI_SS3;
    sck_prev = SPI_SCK;
  end

  // BIG_OSD=1 instance: only the command byte of each frame is scored.
  always @(negedge clk_sys) begin
    if (!big_ss3) begin
      if (bss_prev) begin bbit = 0; bfirst = 1'b1; end
      if (big_sck && !bsck_prev) begin
        bsh = {bsh[6:0], big_di};
        bbit++;
        if (bbit == 8) begin
          bbit = 0;
          if (bfirst) begin
            if (big_q.size() == 0) chk("big_cmd_unexpected", int'(bsh), -1);
            else chk("big_cmd_byte", int'(bsh), int'(big_q.pop_front()));
          end
          bfirst = 1'b0;
        end
      end
    end
    bss_prev = big_ss3;
    bsck_prev = big_sck;
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] line, input logic [7:0] ec,
                       input logic [7:0] eb, input logic keep);
    int n;
    @(negedge clk_sys);
    cmd_op = op; cmd_line = line; cmd_valid = 1'b1;
    if (op != 2'd3) begin exp_q.push_back(ec); big_q.push_back(eb); end
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk_sys); n++; end
    chk("cmd_accept_in_time", int'(n < 200), 1);
    @(posedge clk_sys);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20000) begin @(negedge clk_sys); n++; end
    chk({name, "_done_seen"}, int'(done), 1);
    n = 0;
    while (busy && n < 50) begin @(negedge clk_sys); n++; end
    chk({name, "_busy_after_done"}, n, SS_GAP);
  endtask

  initial begin
    vec_t vecs[4];
    int base_hs, base_done, base_idle, base_sfetch, base_sbad, bad, n;
    vecs[0] = '{op: 2'd1, line: 4'h0, exp_cmd: 8'h41, exp_big: 8'h41, exp_frame: 1};
    vecs[1] = '{op: 2'd0, line: 4'h0, exp_cmd: 8'h40, exp_big: 8'h40, exp_frame: 1};
    vecs[2] = '{op: 2'd2, line: 4'h5, exp_cmd: 8'h25, exp_big: 8'h25, exp_frame: 257};
    vecs[3] = '{op: 2'd2, line: 4'hB, exp_cmd: 8'h23, exp_big: 8'h2B, exp_frame: 257};

    #12;
    chk("reset_outputs", int'({cmd_ready, data_ready, busy, done, SPI_SCK, SPI_SS3, SPI_DI}), 7'b0000010);
    chk("reset_outputs_big", int'({big_cmd_ready, big_data_ready, big_busy, big_done, big_sck, big_ss3, big_di}), 7'b0000010);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("cmd_ready_after_reset", int'(cmd_ready), 1);

    for (int i = 0; i < 4; i++) begin
      base_hs = hs_cnt; base_done = done_cnt;
      src_base = hs_cnt;
      src_en = (vecs[i].op == 2'd2);
      issue(vecs[i].op, vecs[i].line, vecs[i].exp_cmd, vecs[i].exp_big, 1'b0);
      wait_done($sformatf("vec%0d", i));
      repeat (3) @(negedge clk_sys);
      src_en = 1'b0;
      chk($sformatf("vec%0d_handshakes", i), hs_cnt - base_hs, (vecs[i].op == 2'd2) ? LINE_BYTES : 0);
      chk($sformatf("vec%0d_frame_bytes", i), last_bytes, vecs[i].exp_frame);
      chk($sformatf("vec%0d_done_pulses", i), done_cnt - base_done, 1);
      if (i == 0) begin
        chk("enable_sck_pulses", last_rises, 8);
        chk("enable_sck_high_min", last_hi_min, CLK_DIV);
        chk("enable_sck_high_max", last_hi_max, CLK_DIV);
      end
      if (i == 2) begin
        bad = 0;
        for (int k = 0; k < 256; k++) if (buffer[12'h500 + k] !== 8'(k)) bad++;
        chk("line5_buffer_bad_entries", bad, 0);
      end
    end

    // Source underflow for 50 cycles after byte 10.
    base_hs = hs_cnt; base_sfetch = stall_fetch; base_sbad = stall_bad;
    src_base = hs_cnt; stall_at = 11; src_en = 1'b1;
    issue(2'd2, 4'h5, 8'h25, 8'h25, 1'b0);
    wait_done("stall");
    repeat (3) @(negedge clk_sys);
    src_en = 1'b0; stall_at = -1;
    chk("stall_handshakes", hs_cnt - base_hs, LINE_BYTES);
    chk("stall_frame_bytes", last_bytes, 257);
    chk("stall_fetch_cycles_seen", int'(stall_fetch - base_sfetch >= 10), 1);
    chk("stall_sck_or_ss_active", stall_bad - base_sbad, 0);

    // Reset in the middle of byte 100 of a write.
    src_base = hs_cnt; src_en = 1'b1;
    issue(2'd2, 4'h5, 8'h25, 8'h25, 1'b0);
    n = 0;
    while (hs_cnt - src_base < 101 && n < 20000) begin @(negedge clk_sys); n++; end
    chk("reach_byte100", int'(n < 20000), 1);
    repeat (9) @(negedge clk_sys);
    chk("mid_frame_ss3_low", int'(SPI_SS3), 0);
    src_en = 1'b0;
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_ss3_sck", int'({SPI_SS3, SPI_SCK}), 2'b10);
    exp_q.delete();
    big_q.delete();
    repeat (2) @(negedge clk_sys);
    chk("in_reset_outputs", int'({cmd_ready, data_ready, busy, done, SPI_SCK, SPI_SS3}), 6'b000001);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("cmd_ready_after_midreset", int'(cmd_ready), 1);
    issue(2'd0, 4'h0, 8'h40, 8'h40, 1'b0);
    wait_done("post_reset_disable");
    chk("post_reset_frame_bytes", last_bytes, 1);

    // Back-to-back disable, op 3, enable with cmd_valid held high.
    base_done = done_cnt; base_idle = idle_rises;
    gap_arm = 1'b1;
    issue(2'd0, 4'h0, 8'h40, 8'h40, 1'b1);
    issue(2'd3, 4'h0, 8'h00, 8'h00, 1'b1);
    issue(2'd1, 4'h0, 8'h41, 8'h41, 1'b0);
    wait_done("b2b_enable");
    chk("b2b_done_pulses", done_cnt - base_done, 3);
    chk("b2b_sck_edges_while_ss_high", idle_rises - base_idle, 0);
    chk("b2b_min_ss_gap_ok", int'(gap_min >= SS_GAP && gap_min < 999), 1);
    gap_arm = 1'b0;

    repeat (5) @(negedge clk_sys);
    chk("scoreboard_drained", exp_q.size() + big_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
